// File: rtl/prng_dir_fifo_pkg.sv
// Shared types for the PRNG direction FIFO: fp24 vector layout, LFSR width, default decimation.
// Hemisphere-flip constants exist only when PRNG_DIR_HEMI_EN is defined.
package prng_dir_fifo_pkg;

    localparam int FP24_W        = 24;
    localparam int FP24_SIGN_BIT = 23;

    typedef logic [FP24_W-1:0] fp24;
    typedef struct packed {
        fp24 x;
        fp24 y;
        fp24 z;
    } fp24_vec3;

    localparam int VEC_W = $bits(fp24_vec3);

    // One accepted sample per full LFSR refresh.
    localparam int RNG_LFSR_W              = 48;
    localparam int PRNG_DIR_DEFAULT_STRIDE = RNG_LFSR_W;

    typedef enum logic {
        WARM,
        RUN
    } ctrl_state_e;

`ifdef PRNG_DIR_HEMI_EN
    localparam int FP24_DOT_LAT = 3;
    localparam logic [VEC_W-1:0] VEC_SIGN_MASK =
        (VEC_W'(1) << (2*FP24_W + FP24_SIGN_BIT)) |
        (VEC_W'(1) << (FP24_W + FP24_SIGN_BIT)) |
        (VEC_W'(1) << FP24_SIGN_BIT);
`endif

endpackage

// File: rtl/prng_dir_fifo_mem.sv
// Storage array with free-wrapping pointers and a separately tracked occupancy.
// push/pop arrive pre-qualified from the control logic; flush wins over both.
module prng_dir_fifo_mem
    import prng_dir_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [VEC_W-1:0]       wdata,
    output logic [VEC_W-1:0]       head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; head is only meaningful while level != 0.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/prng_dir_fifo.sv
// Warmup-gated, decimating FWFT buffer between the unit-sphere PRNG and the bounce logic.
// Define PRNG_DIR_HEMI_EN to add a normal input and a hemisphere-flipping output stage.
module prng_dir_fifo
    import prng_dir_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int STRIDE = PRNG_DIR_DEFAULT_STRIDE,
    parameter int WARMUP = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VEC_W-1:0]       in_vec,
    input  logic                   flush,
`ifdef PRNG_DIR_HEMI_EN
    input  logic [VEC_W-1:0]       normal,
`endif
    output logic [VEC_W-1:0]       out_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            dropped
);

    localparam int WC_W = $clog2(WARMUP + 1);
    localparam int SC_W = $clog2(STRIDE + 1);
    localparam int LW   = $clog2(DEPTH) + 1;

    ctrl_state_e      state;
    ctrl_state_e      state_nx;
    logic [WC_W-1:0]  warm_cnt;
    logic [SC_W-1:0]  stride_cnt;
    logic             tick;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_valid;
    logic [VEC_W-1:0] head;

    always_comb begin
        state_nx = state;
        case (state)
            WARM:    if (warm_cnt == WC_W'(WARMUP - 1)) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = WARM;
        endcase
    end

    assign tick       = (state == RUN) && (stride_cnt == SC_W'(STRIDE - 1));
    assign fifo_valid = (level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = tick && ((level < LW'(DEPTH)) || pop);
    assign drop       = tick && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WARM;
            warm_cnt   <= '0;
            stride_cnt <= '0;
            dropped    <= '0;
        end else begin
            state <= state_nx;
            if (state == WARM) warm_cnt <= warm_cnt + 1'b1;
            if (state == RUN)  stride_cnt <= tick ? '0 : stride_cnt + 1'b1;
            if (drop && dropped != 16'hFFFF) dropped <= dropped + 1'b1;
        end
    end

    prng_dir_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_vec),
        .head  (head),
        .level (level)
    );

`ifdef PRNG_DIR_HEMI_EN
    localparam int LAT = FP24_DOT_LAT;

    logic [LAT:1]             vld_pipe;
    logic [LAT:1][VEC_W-1:0]  vec_pipe;
    logic                     adv;
    logic                     dot_neg;

    // Whole output pipe stalls while the last stage is held by the consumer.
    assign adv = !vld_pipe[LAT] || out_ready;
    assign pop = fifo_valid && adv;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= fifo_valid;
            for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            vec_pipe[1] <= head;
            for (int i = 2; i <= LAT; i++) vec_pipe[i] <= vec_pipe[i-1];
        end
    end

    fp24_vec3_dot #(
        .LAT(LAT)
    ) u_dot (
        .clk (clk),
        .en  (adv),
        .a   (head),
        .b   (normal),
        .neg (dot_neg)
    );

    assign out_valid = vld_pipe[LAT];
    assign out_vec   = dot_neg ? (vec_pipe[LAT] ^ VEC_SIGN_MASK) : vec_pipe[LAT];
`else
    assign pop       = fifo_valid && out_ready;
    assign out_valid = fifo_valid;
    assign out_vec   = head;
`endif

endmodule

// File: tb/tb_prng_dir_fifo.sv
// Scoreboard bench: DUT a (STRIDE=4, WARMUP=3) against a queue model, DUT b (STRIDE=1) streaming.
module tb_prng_dir_fifo;

    localparam int DEPTH  = 8;
    localparam int STRIDE = 4;
    localparam int WARMUP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_a = 1'b0;
    logic        flush_b = 1'b0;
    logic        out_ready_a = 1'b0;
    logic        out_ready_b = 1'b1;
    logic [71:0] in_vec;
    logic [71:0] out_vec_a, out_vec_b;
    logic        out_valid_a, out_valid_b;
    logic [3:0]  level_a, level_b;
    logic [15:0] dropped_a, dropped_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic [23:0] cyc = '0;
    always @(negedge clk) cyc <= cyc + 24'd1;
    assign in_vec = {cyc, ~cyc, cyc ^ 24'h5a5a5a};

    prng_dir_fifo #(.DEPTH(DEPTH), .STRIDE(STRIDE), .WARMUP(WARMUP)) u_dut_a (
        .clk(clk), .rst(rst), .in_vec(in_vec), .flush(flush_a),
        .out_vec(out_vec_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .level(level_a), .dropped(dropped_a)
    );

    prng_dir_fifo #(.DEPTH(DEPTH), .STRIDE(1), .WARMUP(WARMUP)) u_dut_b (
        .clk(clk), .rst(rst), .in_vec(in_vec), .flush(flush_b),
        .out_vec(out_vec_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .level(level_b), .dropped(dropped_b)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model for DUT a, stepped on the same edges as the DUT.
    logic [71:0] q[$];
    bit m_run = 1'b0;
    int m_wc = 0, m_sc = 0, m_drop = 0;
    bit chk_a = 1'b0, chk_b = 1'b0;

    always @(posedge clk) begin
        bit tick, pop, ok;
        if (rst) begin
            q.delete();
            m_run = 1'b0; m_wc = 0; m_sc = 0; m_drop = 0;
        end else begin
            tick = m_run && (m_sc == STRIDE - 1);
            pop  = (q.size() != 0) && out_ready_a;
            ok   = (q.size() < DEPTH) || pop;
            if (tick && !ok && m_drop < 65535) m_drop++;
            if (flush_a) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (tick && ok) q.push_back(in_vec);
            end
            if (!m_run) begin
                if (m_wc == WARMUP - 1) begin m_run = 1'b1; m_sc = 0; end
                else m_wc++;
            end else m_sc = tick ? 0 : m_sc + 1;
        end
    end

    always @(negedge clk) if (chk_a) begin
        chk("level", 72'(level_a), 72'(q.size()));
        chk("valid", 72'(out_valid_a), 72'(q.size() != 0));
        chk("dropped", 72'(dropped_a), 72'(m_drop));
        if (q.size() != 0) chk("head", out_vec_a, q[0]);
    end

    logic [71:0] prev_in;
    always @(posedge clk) prev_in <= in_vec;

    always @(negedge clk) if (chk_b) begin
        chk("b_level", 72'(level_b), 72'(1));
        chk("b_valid", 72'(out_valid_b), 72'(1));
        chk("b_vec", out_vec_b, prev_in);
        chk("b_drop", 72'(dropped_b), 72'(0));
    end

    initial begin
        int n;
        bit found;
        logic [15:0] d0;
        logic [71:0] exp2;

        repeat (2) @(negedge clk);
        chk_a = 1'b1;
        chk("rst_level", 72'(level_a), 72'(0));
        chk("rst_valid", 72'(out_valid_a), 72'(0));
        rst = 1'b0;

        // First push lands one cycle after the first tick.
        n = 0;
        while (!out_valid_a && n < 20) begin @(negedge clk); n++; end
        chk("first_valid_cycle", 72'(n), 72'(WARMUP + STRIDE));
        chk_b = 1'b1;

        // Fill with consumer stalled, then keep ticking into a full FIFO.
        repeat (50) @(negedge clk);
        chk("fill_level", 72'(level_a), 72'(DEPTH));
        chk("drops_seen", 72'(dropped_a != 0), 72'(1));

        // Pop on a tick while full: push accepted, no drop.
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_run && m_sc == STRIDE - 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("tick_found", 72'(found), 72'(1));
        d0 = dropped_a;
        exp2 = q[1];
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("full_pp_level", 72'(level_a), 72'(DEPTH));
        chk("full_pp_drop", 72'(dropped_a), 72'(d0));
        chk("second_oldest", out_vec_a, exp2);

        // Drain to 5, then flush together with a push and a pop.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_run && m_sc == STRIDE - 1 && q.size() == 5) begin found = 1'b1; break; end
            out_ready_a = (q.size() > 5);
        end
        chk("flush_setup", 72'(found), 72'(1));
        flush_a = 1'b1;
        out_ready_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        out_ready_a = 1'b0;
        chk("flush_level", 72'(level_a), 72'(0));
        chk("flush_valid", 72'(out_valid_a), 72'(0));
        n = 0;
        while (!out_valid_a && n < 10) begin @(negedge clk); n++; end
        chk("post_flush_level", 72'(level_a), 72'(1));
        chk("post_flush_head", out_vec_a, prev_in);

        // Long STRIDE=1 soak on DUT b while DUT a saturates.
        repeat (1000) @(negedge clk);
        chk_b = 1'b0;

        // Bring DUT a to level 6, then a single-cycle reset.
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 6) begin found = 1'b1; break; end
            out_ready_a = (q.size() > 6);
        end
        out_ready_a = 1'b0;
        chk("rst_setup", 72'(found), 72'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WARMUP + STRIDE; i++) begin
            chk("rewarm_valid", 72'(out_valid_a), 72'(0));
            chk("rewarm_drop", 72'(dropped_a), 72'(0));
            chk("rewarm_level", 72'(level_a), 72'(0));
            @(negedge clk);
        end
        chk("rewarm_first", 72'(out_valid_a), 72'(1));

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_dir_fifo.md
Name: prng_dir_fifo

Overview:
- Sits directly downstream of the LFSR unit-sphere PRNG. Consumes its free-running fp24_vec3 stream, which produces one normalized vector per cycle.
- Drops the pipeline-warmup garbage after reset.
- Decimates the stream so each consecutive accepted sample comes from a fully refreshed 48-bit LFSR state. Adjacent raw samples differ by a single shift and are strongly correlated.
- Buffers accepted vectors in a small FIFO and serves them to the ray-bounce logic over a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- STRIDE, 48, cycles between accepted samples; at least 1. A value of 1 accepts every cycle.
- WARMUP, 16, cycles after reset release during which in_vec is ignored; covers the source converter/normalizer latency.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_vec  input  72  fp24_vec3 from the PRNG, updates every cycle
- flush  input  1  single-cycle pulse; empties the FIFO
- out_vec  output  72  fp24_vec3 head-of-FIFO vector
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- level  output  $clog2(DEPTH)+1  current occupancy
- dropped  output  16  saturating count of decimated samples lost to full FIFO

Behaviour:
- All state is registered; clk only; rst is synchronous, active-high.
- Reset: rd_ptr=wr_ptr=0, level=0, out_valid=0, dropped=0, warm_cnt=0, stride_cnt=0. out_vec is undefined but deterministic while out_valid=0.
- Warmup state WARM: warm_cnt counts 0..WARMUP-1. No samples are taken. At warm_cnt==WARMUP-1 the block moves to RUN on the next cycle. This state is never re-entered except by rst.
- RUN: stride_cnt counts 0..STRIDE-1 and wraps. A "tick" is stride_cnt==STRIDE-1, so the first tick comes STRIDE cycles after entering RUN.
- Push: on a tick, in_vec is written to mem[wr_ptr] if (level<DEPTH) or pop occurs the same cycle. Otherwise the sample is dropped and dropped increments, saturating at 16'hFFFF.
- Pop: out_valid && out_ready. rd_ptr advances; out_vec shows the new head the next cycle.
- out_vec = mem[rd_ptr]. The FIFO is first-word-fall-through: a vector pushed at cycle t is visible with out_valid=1 at t+1 if the FIFO was empty.
- Simultaneous push and pop: level is unchanged; both pointers advance. This holds in the full case too, so no sample is dropped.
- Pointers are log2(DEPTH) bits and wrap naturally. level is tracked separately, so full is level==DEPTH and empty is level==0.
- flush: rd_ptr=wr_ptr=0 and level=0 next cycle. It overrides push and pop in the same cycle. stride_cnt, the warmup state and dropped are untouched.
- rst mid-operation: all contents are discarded and WARM restarts. Outstanding consumer handshakes are void.
- out_valid is combinational from registered level (level!=0). out_vec and out_valid do not change while out_valid && !out_ready, except by flush or rst.

Optional Feature:
- Macro: PRNG_DIR_HEMI_EN.
- When defined, the block adds input normal (72-bit fp24_vec3) and output out_vec becomes the head vector with all three fp24 sign bits inverted when dot(head, normal)<0.
  - The dot sign is computed from the head entry by an fp24_vec3_dot instance.
  - out_valid is delayed by its latency through a registered output stage. That stage holds while !out_ready.
  - normal must be held stable while out_valid && !out_ready.
- When undefined: no normal port; out_vec is the raw FIFO head with the latency above.

Decomposition:
- fp24, fp24_vec3 and the FP24 sign-bit index constants come from the existing shared fp24 package.
- PRNG_DIR_DEFAULT_STRIDE=48 goes in the rng package next to the LFSR width.
- One natural sub-module: prng_dir_fifo_mem, holding the storage array plus pointer/level logic with push/pop/flush inputs. Warmup and stride control stay in the top module.

Test Plan:
- Reset, then in_vec = cycle counter, STRIDE=4, WARMUP=3, out_ready=0.
  - out_valid first rises 1 cycle after the first tick, at cycle 3+4.
  - Entries are the in_vec values at ticks only, spaced exactly 4 apart.
  - level saturates at 8; further ticks increment dropped 1 per tick.
- FIFO full, out_ready=1 on a tick cycle.
  - level stays 8 and dropped does not increment.
  - The next pop returns the second-oldest entry.
- STRIDE=1, out_ready=1 constantly.
  - level stays at 1 and out_vec tracks in_vec delayed one cycle.
  - Zero drops over 1000 cycles.
- level=5, flush asserted with a push and pop in the same cycle.
  - Next cycle level=0 and out_valid=0.
  - The following tick pushes cleanly to the FIFO start.
- Assert rst for 1 cycle with level=6.
  - Everything clears, out_valid=0 for WARMUP+STRIDE cycles, and dropped=0.
- PRNG_DIR_HEMI_EN with normal=(0,0,+1.0) and head (0,0,-1.0).
  - Output (0,0,+1.0) with the x/y signs also flipped.
  - Head (0.6,0,0.8) passes through unchanged.
